rsv_dispatch_pip3: RTL and testbench

- Issue-side counterpart of the 3-stage scoreboard: holds decoded uops waiting for issue in two per-pipe FIFOs (pip0 = EX, pip1 = MUL).
- Each cycle it presents both queue heads plus an age/order code to the scoreboard.
- It pops whichever head the scoreboard grants via its rsv-select output.
- Issue is strictly oldest-first across both pipes.

---
 rtl/rsv_dispatch_pip3_pkg.sv | 37 +++
 rtl/rsv_dispatch_pip3_if.sv | 33 +++
 rtl/rsv_fifo_pip3.sv | 62 ++++++
 rtl/rsv_dispatch_pip3.sv | 86 ++++++++
 tb/tb_rsv_dispatch_pip3.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/rsv_dispatch_pip3_pkg.sv
// Shared codes and widths for the reservation dispatch and its scoreboard.
package rsv_dispatch_pip3_pkg;

    localparam int unsigned W_PA_REG     = 5;
    localparam int unsigned W_PD_UOPS    = 6;
    localparam int unsigned W_PC_SEL_RSV = 2;
    localparam int unsigned W_PC_SEL_ODR = 2;
    localparam int unsigned S_depth      = 4;
    localparam int unsigned W_ptr        = 2;
    localparam int unsigned W_seq        = 4;

    localparam logic [W_PD_UOPS-1:0] unused_op = '1;

    localparam logic [W_PC_SEL_RSV-1:0] V_unpip = 2'b00;
    localparam logic [W_PC_SEL_RSV-1:0] V_pip0  = 2'b01;
    localparam logic [W_PC_SEL_RSV-1:0] V_pip1  = 2'b10;

    localparam logic [W_PC_SEL_ODR-1:0] V_odrnone = 2'b00;
    localparam logic [W_PC_SEL_ODR-1:0] V_odrf0   = 2'b01;
    localparam logic [W_PC_SEL_ODR-1:0] V_odrf1   = 2'b10;

    typedef struct packed {
        logic [W_PD_UOPS-1:0] uops;
        logic [W_PA_REG-1:0]  rd;
        logic [W_seq-1:0]     seq;
    } rsv_entry_t;

    // True when tag a was stamped before tag b; valid while fewer than
    // 2^(W_seq-1) enqueues separate them, which FIFO capacity guarantees.
    function automatic logic seq_older(input logic [W_seq-1:0] a,
                                       input logic [W_seq-1:0] b);
        logic [W_seq-1:0] diff;
        diff = a - b;
        return diff[W_seq-1];
    endfunction

endpackage

// File: rtl/rsv_dispatch_pip3_if.sv
// Enqueue, head-presentation and grant signals between decode, dispatch and scoreboard.
interface rsv_dispatch_pip3_if
    import rsv_dispatch_pip3_pkg::*;
();
    logic                    CDI_PC_valid_in;
    logic [W_PC_SEL_RSV-1:0] CDI_PC_pip_in;
    logic [W_PD_UOPS-1:0]    CDI_PD_uops_in;
    logic [W_PA_REG-1:0]     CDI_PD_rd_in;
    logic                    CDO_PC_full0;
    logic                    CDO_PC_full1;
    logic [W_PD_UOPS-1:0]    CDO_PD_uops0;
    logic [W_PD_UOPS-1:0]    CDO_PD_uops1;
    logic [W_PA_REG-1:0]     CDO_PD_rd0;
    logic [W_PA_REG-1:0]     CDO_PD_rd1;
    logic [W_PC_SEL_ODR-1:0] CDO_PC_odr;
    logic [W_PC_SEL_RSV-1:0] CDI_PC_selrsv;
    logic                    CFI_PC_clear;

    modport master (
        output CDI_PC_valid_in, CDI_PC_pip_in, CDI_PD_uops_in, CDI_PD_rd_in,
               CDI_PC_selrsv, CFI_PC_clear,
        input  CDO_PC_full0, CDO_PC_full1, CDO_PD_uops0, CDO_PD_uops1,
               CDO_PD_rd0, CDO_PD_rd1, CDO_PC_odr
    );

    modport slave (
        input  CDI_PC_valid_in, CDI_PC_pip_in, CDI_PD_uops_in, CDI_PD_rd_in,
               CDI_PC_selrsv, CFI_PC_clear,
        output CDO_PC_full0, CDO_PC_full1, CDO_PD_uops0, CDO_PD_uops1,
               CDO_PD_rd0, CDO_PD_rd1, CDO_PC_odr
    );

endinterface

// File: rtl/rsv_fifo_pip3.sv
// Per-pipe uop FIFO: push rejected when full, pop ignored when empty, flush dominates.
module rsv_fifo_pip3
    import rsv_dispatch_pip3_pkg::*;
#(
    parameter int unsigned W_data = $bits(rsv_entry_t),
    parameter int unsigned DEPTH  = S_depth,
    parameter int unsigned W_ADDR = W_ptr
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [W_data-1:0] din,
    output logic [W_data-1:0] head,
    output logic              full,
    output logic              empty
);

    logic [W_data-1:0] mem [DEPTH];
    logic [W_ADDR-1:0] wr_ptr;
    logic [W_ADDR-1:0] rd_ptr;
    logic [W_ADDR:0]   count;
    logic              do_push;
    logic              do_pop;

    // Accept decisions use the pre-edge occupancy only.
    always_comb begin
        full    = (count == (W_ADDR+1)'(DEPTH));
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = mem[rd_ptr];
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only observed through a non-empty head.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rsv_dispatch_pip3.sv
// Dual-pipe reservation dispatch: age-stamped uop queues with oldest-first order code.
module rsv_dispatch_pip3
    import rsv_dispatch_pip3_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    rsv_dispatch_pip3_if.slave bus
);

    logic [W_seq-1:0] seq_cnt;
    rsv_entry_t       din;
    rsv_entry_t       head0;
    rsv_entry_t       head1;
    logic             full0, full1;
    logic             empty0, empty1;
    logic             push0, push1;
    logic             pop0, pop1;
    logic             accept;

    // Enqueue steering and grant decode.
    always_comb begin
        din    = '{uops: bus.CDI_PD_uops_in, rd: bus.CDI_PD_rd_in, seq: seq_cnt};
        push0  = bus.CDI_PC_valid_in && (bus.CDI_PC_pip_in == V_pip0);
        push1  = bus.CDI_PC_valid_in && (bus.CDI_PC_pip_in == V_pip1);
        accept = (push0 && !full0) || (push1 && !full1);
        pop0   = (bus.CDI_PC_selrsv == V_pip0);
        pop1   = (bus.CDI_PC_selrsv == V_pip1);
    end

    rsv_fifo_pip3 #(
        .W_data ($bits(rsv_entry_t)),
        .DEPTH  (S_depth),
        .W_ADDR (W_ptr)
    ) u_fifo0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push0),
        .pop   (pop0),
        .flush (bus.CFI_PC_clear),
        .din   (din),
        .head  (head0),
        .full  (full0),
        .empty (empty0)
    );

    rsv_fifo_pip3 #(
        .W_data ($bits(rsv_entry_t)),
        .DEPTH  (S_depth),
        .W_ADDR (W_ptr)
    ) u_fifo1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push1),
        .pop   (pop1),
        .flush (bus.CFI_PC_clear),
        .din   (din),
        .head  (head1),
        .full  (full1),
        .empty (empty1)
    );

    // Global age stamp: advances on each accepted enqueue, zeroed by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                seq_cnt <= '0;
        else if (bus.CFI_PC_clear) seq_cnt <= '0;
        else if (accept)           seq_cnt <= seq_cnt + 1'b1;
    end

    // Head presentation and age comparison across the two queues.
    always_comb begin
        bus.CDO_PC_full0 = full0;
        bus.CDO_PC_full1 = full1;
        bus.CDO_PD_uops0 = empty0 ? unused_op : head0.uops;
        bus.CDO_PD_uops1 = empty1 ? unused_op : head1.uops;
        bus.CDO_PD_rd0   = empty0 ? '0 : head0.rd;
        bus.CDO_PD_rd1   = empty1 ? '0 : head1.rd;
        bus.CDO_PC_odr   = V_odrnone;
        case ({empty0, empty1})
            2'b01:   bus.CDO_PC_odr = V_odrf0;
            2'b10:   bus.CDO_PC_odr = V_odrf1;
            2'b00:   bus.CDO_PC_odr = seq_older(head0.seq, head1.seq) ? V_odrf0 : V_odrf1;
            default: bus.CDO_PC_odr = V_odrnone;
        endcase
    end

endmodule

// File: tb/tb_rsv_dispatch_pip3.sv
// Directed bench for rsv_dispatch_pip3: reset, issue, age order, full, clear, wrap.
module tb_rsv_dispatch_pip3;
    import rsv_dispatch_pip3_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    rsv_dispatch_pip3_if bus ();

    rsv_dispatch_pip3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.CDI_PC_valid_in = 1'b0;
        bus.CDI_PC_pip_in   = V_unpip;
        bus.CDI_PD_uops_in  = '0;
        bus.CDI_PD_rd_in    = '0;
        bus.CDI_PC_selrsv   = V_unpip;
        bus.CFI_PC_clear    = 1'b0;
    endtask

    // One clock with the given inputs applied; returns 1 time unit after the edge.
    task automatic cycle(input logic v, input logic [1:0] p, input logic [5:0] u,
                         input logic [4:0] r, input logic [1:0] s, input logic c);
        bus.CDI_PC_valid_in = v;
        bus.CDI_PC_pip_in   = p;
        bus.CDI_PD_uops_in  = u;
        bus.CDI_PD_rd_in    = r;
        bus.CDI_PC_selrsv   = s;
        bus.CFI_PC_clear    = c;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          h;
        int          sz;
        logic [1:0]  gsel;
        logic [1:0]  eodr;
        logic [5:0]  ehead;
        logic [5:0]  ohead;

        idle_inputs();
        #3;
        chk("rst_uops0", 32'(bus.CDO_PD_uops0), 32'h3F);
        chk("rst_uops1", 32'(bus.CDO_PD_uops1), 32'h3F);
        chk("rst_rd0",   32'(bus.CDO_PD_rd0),   32'h0);
        chk("rst_rd1",   32'(bus.CDO_PD_rd1),   32'h0);
        chk("rst_odr",   32'(bus.CDO_PC_odr),   32'h0);
        chk("rst_full0", 32'(bus.CDO_PC_full0), 32'h0);
        chk("rst_full1", 32'(bus.CDO_PC_full1), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic issue
        cycle(1'b1, 2'b01, 6'h01, 5'd3, 2'b00, 1'b0);
        cycle(1'b1, 2'b10, 6'h02, 5'd7, 2'b00, 1'b0);
        chk("basic_uops0", 32'(bus.CDO_PD_uops0), 32'h01);
        chk("basic_rd0",   32'(bus.CDO_PD_rd0),   32'd3);
        chk("basic_uops1", 32'(bus.CDO_PD_uops1), 32'h02);
        chk("basic_rd1",   32'(bus.CDO_PD_rd1),   32'd7);
        chk("basic_odr",   32'(bus.CDO_PC_odr),   32'h1);
        cycle(1'b0, 2'b00, 6'h00, 5'd0, 2'b01, 1'b0);
        chk("grant0_uops0", 32'(bus.CDO_PD_uops0), 32'h3F);
        chk("grant0_rd0",   32'(bus.CDO_PD_rd0),   32'h0);
        chk("grant0_odr",   32'(bus.CDO_PC_odr),   32'h2);
        cycle(1'b0, 2'b00, 6'h00, 5'd0, 2'b10, 1'b0);
        chk("grant1_odr",   32'(bus.CDO_PC_odr),   32'h0);
        chk("grant1_uops1", 32'(bus.CDO_PD_uops1), 32'h3F);

        // Age order: pip1 older than pip0
        cycle(1'b1, 2'b10, 6'h05, 5'd1, 2'b00, 1'b0);
        cycle(1'b1, 2'b01, 6'h04, 5'd2, 2'b00, 1'b0);
        chk("age_odr_f1", 32'(bus.CDO_PC_odr), 32'h2);
        cycle(1'b0, 2'b00, 6'h00, 5'd0, 2'b10, 1'b0);
        chk("age_odr_f0", 32'(bus.CDO_PC_odr), 32'h1);
        chk("age_uops0",  32'(bus.CDO_PD_uops0), 32'h04);
        cycle(1'b0, 2'b00, 6'h00, 5'd0, 2'b01, 1'b0);
        chk("age_drain",  32'(bus.CDO_PC_odr), 32'h0);

        // Full pip0
        for (int k = 0; k < 4; k++)
            cycle(1'b1, 2'b01, 6'(8'h10 + k), 5'(k), 2'b00, 1'b0);
        chk("full_full0", 32'(bus.CDO_PC_full0), 32'h1);
        chk("full_full1", 32'(bus.CDO_PC_full1), 32'h0);
        cycle(1'b1, 2'b01, 6'h14, 5'd9, 2'b00, 1'b0);
        chk("full_drop_head", 32'(bus.CDO_PD_uops0), 32'h10);
        chk("full_drop_full", 32'(bus.CDO_PC_full0), 32'h1);
        cycle(1'b1, 2'b01, 6'h15, 5'd9, 2'b01, 1'b0);
        chk("popenq_full0", 32'(bus.CDO_PC_full0), 32'h0);
        chk("popenq_head",  32'(bus.CDO_PD_uops0), 32'h11);
        chk("popenq_rd",    32'(bus.CDO_PD_rd0),   32'd1);
        cycle(1'b1, 2'b01, 6'h16, 5'd6, 2'b00, 1'b0);
        chk("count3_refill", 32'(bus.CDO_PC_full0), 32'h1);

        // Clear dominates a same-cycle enqueue
        cycle(1'b1, 2'b10, 6'h20, 5'd1, 2'b00, 1'b1);
        chk("clr_uops0", 32'(bus.CDO_PD_uops0), 32'h3F);
        chk("clr_uops1", 32'(bus.CDO_PD_uops1), 32'h3F);
        chk("clr_odr",   32'(bus.CDO_PC_odr),   32'h0);
        chk("clr_full0", 32'(bus.CDO_PC_full0), 32'h0);

        // Grant to empty pip0 and reserved code leave pip1 untouched
        cycle(1'b1, 2'b10, 6'h21, 5'd5, 2'b00, 1'b0);
        cycle(1'b0, 2'b00, 6'h00, 5'd0, 2'b01, 1'b0);
        chk("egrant_uops1", 32'(bus.CDO_PD_uops1), 32'h21);
        chk("egrant_rd1",   32'(bus.CDO_PD_rd1),   32'd5);
        chk("egrant_odr",   32'(bus.CDO_PC_odr),   32'h2);
        chk("egrant_uops0", 32'(bus.CDO_PD_uops0), 32'h3F);
        cycle(1'b0, 2'b00, 6'h00, 5'd0, 2'b11, 1'b0);
        chk("g11_uops1", 32'(bus.CDO_PD_uops1), 32'h21);
        cycle(1'b0, 2'b00, 6'h00, 5'd0, 2'b10, 1'b0);
        chk("g10_odr", 32'(bus.CDO_PC_odr), 32'h0);

        // Wrap: entry k goes to pip0 when k even, uop k+1; grant oldest when two pending
        h = 0;
        for (int i = 0; i < 40; i++) begin
            sz = i - h;
            gsel = V_unpip;
            if (sz == 0) begin
                chk("wrap_odr_empty", 32'(bus.CDO_PC_odr), 32'h0);
            end else begin
                eodr  = (h % 2 == 0) ? V_odrf0 : V_odrf1;
                ehead = 6'(h + 1);
                ohead = (h % 2 == 0) ? bus.CDO_PD_uops0 : bus.CDO_PD_uops1;
                chk("wrap_odr",  32'(bus.CDO_PC_odr), 32'(eodr));
                chk("wrap_head", 32'(ohead), 32'(ehead));
            end
            if (sz >= 2) begin
                gsel = (h % 2 == 0) ? V_pip0 : V_pip1;
                h++;
            end
            cycle(1'b1, (i % 2 == 0) ? V_pip0 : V_pip1, 6'(i + 1), 5'(i), gsel, 1'b0);
        end
        chk("wrap_end_odr",   32'(bus.CDO_PC_odr),   32'(V_odrf0));
        chk("wrap_end_uops0", 32'(bus.CDO_PD_uops0), 32'd39);
        chk("wrap_end_uops1", 32'(bus.CDO_PD_uops1), 32'd40);

        // Asynchronous reset mid-operation
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_uops0", 32'(bus.CDO_PD_uops0), 32'h3F);
        chk("arst_uops1", 32'(bus.CDO_PD_uops1), 32'h3F);
        chk("arst_odr",   32'(bus.CDO_PC_odr),   32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, 2'b00, 6'h00, 5'd0, 2'b00, 1'b0);
        chk("arst_after_rd1", 32'(bus.CDO_PD_rd1), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
